out_uart_display: RTL and testbench

- Output stage directly downstream of the CPU's output register (OI path).
- Latches the byte the controller sends on an OUT instruction and drives it on the two 7-segment digit ports (led2 high nibble, led1 low nibble).
- Serialises the byte as UART 8N1 on tx.
- Exposes busy so the controller can stall the OUT instruction until the transfer completes.

---
 rtl/out_uart_display.sv | 155 +++++++++++++++
 tb/tb_out_uart_display.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/out_uart_display.sv
// Output stage for the OUT instruction: latches the byte, shows it on two 7-segment
// digits and serialises it as UART 8N1 on tx, with busy/done/overrun handshake.
module out_uart_display #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic [7:0] out_reg,
    output logic [6:0] led1,
    output logic [6:0] led2,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b0111111;
            4'h1: seg7 = 7'b0000110;
            4'h2: seg7 = 7'b1011011;
            4'h3: seg7 = 7'b1001111;
            4'h4: seg7 = 7'b1100110;
            4'h5: seg7 = 7'b1101101;
            4'h6: seg7 = 7'b1111101;
            4'h7: seg7 = 7'b0000111;
            4'h8: seg7 = 7'b1111111;
            4'h9: seg7 = 7'b1101111;
            4'hA: seg7 = 7'b1110111;
            4'hB: seg7 = 7'b1111100;
            4'hC: seg7 = 7'b0111001;
            4'hD: seg7 = 7'b1011110;
            4'hE: seg7 = 7'b1111001;
            default: seg7 = 7'b1110001;
        endcase
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       out_reg_q, out_reg_d;
    logic             tx_q,      tx_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             overrun_q, overrun_d;
    logic             tick;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        out_reg_d = out_reg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (load & (state_q != S_IDLE));
        tick      = (cnt_q == '0);

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    out_reg_d = data_in;
                    shift_d   = data_in;
                    busy_d    = 1'b1;
                    state_d   = S_START;
                    cnt_d     = CNT_RELOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_d   = CNT_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (tick) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        // tx is registered from the next state so it moves on the same edge as busy.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            out_reg_q <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            out_reg_q <= out_reg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_reg = out_reg_q;
    assign led1    = seg7(out_reg_q[3:0]);
    assign led2    = seg7(out_reg_q[7:4]);
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_out_uart_display.sv
// Scoreboard bench for out_uart_display: expected tx bits and done bytes are queued
// at stimulus time and consumed by per-instance monitors on the falling edge.
module tb_out_uart_display;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_F = 7'b1110001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load4 = 1'b0, load2 = 1'b0;
    logic [7:0] data4 = 8'h00, data2 = 8'h00;
    logic [7:0] out_reg4, out_reg2;
    logic [6:0] led1_4, led2_4, led1_2, led2_2;
    logic       tx4, busy4, done4, ovr4;
    logic       tx2, busy2, done2, ovr2;

    int checks = 0;
    int failures = 0;

    logic       q4[$];
    logic       q2[$];
    logic [7:0] dq4[$];
    logic [7:0] dq2[$];

    always #5 clk = ~clk;

    out_uart_display #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load4), .data_in(data4),
        .out_reg(out_reg4), .led1(led1_4), .led2(led2_4),
        .tx(tx4), .busy(busy4), .done(done4), .overrun(ovr4)
    );

    out_uart_display #(.CLKS_PER_BIT(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .load(load2), .data_in(data2),
        .out_reg(out_reg2), .led1(led1_2), .led2(led2_2),
        .tx(tx2), .busy(busy2), .done(done2), .overrun(ovr2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected line: start bit, 8 data bits LSB first, stop bit, each cpb cycles.
    task automatic push_frame(input int cpb, input logic [7:0] b);
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < cpb; c++) begin
                logic v;
                if (s == 0) v = 1'b0;
                else if (s == 9) v = 1'b1;
                else v = b[s-1];
                if (cpb == 4) q4.push_back(v); else q2.push_back(v);
            end
        end
        if (cpb == 4) dq4.push_back(b); else dq2.push_back(b);
    endtask

    task automatic mon4();
        forever begin
            @(negedge clk);
            if (busy4) begin
                if (q4.size() == 0) chk("busy4_unexpected", busy4, 1'b0);
                else chk("tx4_bit", tx4, q4.pop_front());
            end
            if (done4) begin
                chk("tx4_bits_left_at_done", q4.size(), 0);
                if (dq4.size() == 0) chk("done4_unexpected", done4, 1'b0);
                else chk("done4_out_reg", out_reg4, dq4.pop_front());
            end
        end
    endtask

    task automatic mon2();
        forever begin
            @(negedge clk);
            if (busy2) begin
                if (q2.size() == 0) chk("busy2_unexpected", busy2, 1'b0);
                else chk("tx2_bit", tx2, q2.pop_front());
            end
            if (done2) begin
                chk("tx2_bits_left_at_done", q2.size(), 0);
                if (dq2.size() == 0) chk("done2_unexpected", done2, 1'b0);
                else chk("done2_out_reg", out_reg2, dq2.pop_front());
            end
        end
    endtask

    task automatic wait_done4(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    initial begin
        fork
            mon4();
            mon2();
        join_none

        // Reset state, then 20 idle cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx4, 1'b1);
        chk("rst_busy", busy4, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_tx", tx4, 1'b1);
        chk("idle_busy", busy4, 1'b0);
        chk("idle_done", done4, 1'b0);
        chk("idle_overrun", ovr4, 1'b0);
        chk("idle_out_reg", out_reg4, 8'h00);
        chk("idle_led1", led1_4, SEG_0);
        chk("idle_led2", led2_4, SEG_0);

        // A5 frame; load 3C at cycle 10 must be ignored and flag overrun
        push_frame(4, 8'hA5);
        load4 = 1'b1; data4 = 8'hA5;
        @(posedge clk); #1;
        load4 = 1'b0; data4 = 8'h5A;
        chk("a5_out_reg_next_cycle", out_reg4, 8'hA5);
        repeat (8) @(posedge clk);
        #1;
        load4 = 1'b1; data4 = 8'h3C;
        @(posedge clk); #1;
        load4 = 1'b0; data4 = 8'h00;
        chk("overrun_set", ovr4, 1'b1);
        chk("overrun_out_reg_kept", out_reg4, 8'hA5);

        wait_done4("a5_done_seen");
        chk("a5_out_reg", out_reg4, 8'hA5);
        chk("a5_led2", led2_4, SEG_A);
        chk("a5_led1", led1_4, SEG_5);
        chk("a5_overrun_held", ovr4, 1'b1);
        chk("a5_busy_low_in_done", busy4, 1'b0);

        // Back-to-back: load 0F in the done cycle
        #1;
        push_frame(4, 8'h0F);
        load4 = 1'b1; data4 = 8'h0F;
        @(posedge clk); #1;
        load4 = 1'b0;
        chk("b2b_busy", busy4, 1'b1);
        chk("b2b_tx_start", tx4, 1'b0);
        wait_done4("0f_done_seen");
        chk("0f_out_reg", out_reg4, 8'h0F);
        chk("0f_led2", led2_4, SEG_0);
        chk("0f_led1", led1_4, SEG_F);
        chk("0f_overrun_held", ovr4, 1'b1);

        // FF frame aborted by reset at cycle 18
        @(posedge clk); #1;
        push_frame(4, 8'hFF);
        load4 = 1'b1; data4 = 8'hFF;
        @(posedge clk); #1;
        load4 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("pre_abort_busy", busy4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", tx4, 1'b1);
        chk("abort_busy", busy4, 1'b0);
        q4.delete();
        dq4.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_abort_tx", tx4, 1'b1);
        chk("post_abort_busy", busy4, 1'b0);
        chk("post_abort_done", done4, 1'b0);
        chk("post_abort_overrun", ovr4, 1'b0);
        chk("post_abort_out_reg", out_reg4, 8'h00);

        // CLKS_PER_BIT=2, byte 00
        begin
            int n;
            n = 0;
            push_frame(2, 8'h00);
            load2 = 1'b1; data2 = 8'h00;
            @(posedge clk); #1;
            load2 = 1'b0;
            chk("cpb2_tx_start", tx2, 1'b0);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (busy2) n++;
            end
            chk("cpb2_busy_len", n, 20);
            chk("cpb2_tx_idle", tx2, 1'b1);
        end

        chk("q4_empty_end", q4.size(), 0);
        chk("q2_empty_end", q2.size(), 0);
        chk("dq4_empty_end", dq4.size(), 0);
        chk("dq2_empty_end", dq2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
